// File: rtl/sample_scheduler_10hz_pkg.sv
// Shared definitions for the 10 Hz sample scheduler.
// Contents:
//   sched_state_e      - frame sequencer states (IDLE, REQ, GAP, FIN)
//   DEF_NUM_SENSORS    - default number of polled sensor ports
//   DEF_TIMEOUT_CYCLES - default per-sensor REQ timeout in 1 MHz cycles
//   DEF_TS_WIDTH       - default mission timestamp width
//   OVERRUN_MAX        - saturation limit of the 8-bit overrun counter
//   sat_inc8           - saturating increment used by the overrun counter
package sample_scheduler_10hz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } sched_state_e;

  localparam int DEF_NUM_SENSORS    = 3;
  localparam int DEF_TIMEOUT_CYCLES = 50000;
  localparam int DEF_TS_WIDTH       = 32;

  localparam logic [7:0] OVERRUN_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == OVERRUN_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sample_scheduler_10hz_sync_rise_detect.sv
// Three-flop synchronizer with rising-edge pulse output.
// Ports:
//   clk      in  - destination clock
//   rst_n    in  - asynchronous active-low reset
//   async_in in  - asynchronous level to be synchronized
//   rise     out - one-cycle pulse when the synchronized level goes 0->1
// RESET_VAL sets the reset value of all three flops. Resetting to 1 means an
// input that is already high when reset releases does not produce a pulse.
module sync_rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1_d, s2_d, s3_d;
  logic s1_q, s2_q, s3_q;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
      s3_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s1 is the metastability-catching stage; the edge is taken one stage later.
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/sample_scheduler_10hz.sv
// Frame scheduler driven by the 10 Hz frame clock, running in the 1 MHz domain.
// Each rising edge of CLK_10HZ_IN advances TIMESTAMP and, when idle, starts a
// frame that polls sensors 0..NUM_SENSORS-1 in order over REQ/DONE with a
// per-sensor timeout.
// Ports:
//   CLK_1MHZ_IN    in  - system clock
//   RESET_N        in  - asynchronous active-low reset
//   CLK_10HZ_IN    in  - 10 Hz frame clock, asynchronous to CLK_1MHZ_IN
//   SENSOR_REQ     out - poll request, at most one bit high
//   SENSOR_DONE    in  - sensor completion (level or pulse)
//   TIMESTAMP      out - number of 10 Hz rising edges since reset (wraps)
//   FRAME_START    out - one-cycle pulse when a frame begins
//   FRAME_DONE     out - one-cycle pulse when all sensors were handled
//   TIMEOUT_FLAGS  out - sensors that timed out in the current/last frame
//   OVERRUN_CNT    out - ticks that arrived mid-frame, saturating at 255
module sample_scheduler_10hz
  import sample_scheduler_10hz_pkg::*;
#(
  parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TS_WIDTH       = DEF_TS_WIDTH
) (
  input  logic                   CLK_1MHZ_IN,
  input  logic                   RESET_N,
  input  logic                   CLK_10HZ_IN,
  output logic [NUM_SENSORS-1:0] SENSOR_REQ,
  input  logic [NUM_SENSORS-1:0] SENSOR_DONE,
  output logic [TS_WIDTH-1:0]    TIMESTAMP,
  output logic                   FRAME_START,
  output logic                   FRAME_DONE,
  output logic [NUM_SENSORS-1:0] TIMEOUT_FLAGS,
  output logic [7:0]             OVERRUN_CNT
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SENSORS - 1);

  logic tick;

  sched_state_e            state_d, state_q;
  logic [IDX_W-1:0]        idx_d, idx_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [NUM_SENSORS-1:0]  req_d, req_q;
  logic [TS_WIDTH-1:0]     ts_d, ts_q;
  logic [NUM_SENSORS-1:0]  flags_d, flags_q;
  logic [7:0]              ovr_d, ovr_q;
  logic                    fstart_d, fstart_q;
  logic                    fdone_d, fdone_q;

  sync_rise_detect #(
    .RESET_VAL (1'b1)
  ) u_tick_sync (
    .clk      (CLK_1MHZ_IN),
    .rst_n    (RESET_N),
    .async_in (CLK_10HZ_IN),
    .rise     (tick)
  );

  // Next-state and output logic. The timestamp counts every tick regardless
  // of state; a tick outside IDLE is only counted as an overrun and dropped.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    ts_d     = ts_q;
    flags_d  = flags_q;
    ovr_d    = ovr_q;
    fstart_d = 1'b0;
    fdone_d  = 1'b0;

    if (tick) begin
      ts_d = ts_q + TS_WIDTH'(1);
      if (state_q != ST_IDLE) begin
        ovr_d = sat_inc8(ovr_q);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          fstart_d = 1'b1;
          flags_d  = '0;
          idx_d    = '0;
          cnt_d    = '0;
          req_d    = '0;
          req_d[0] = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // DONE is checked first so it wins over a timeout on the same edge.
        if (SENSOR_DONE[idx_q]) begin
          req_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q == CNT_LAST) begin
          flags_d[idx_q] = 1'b1;
          req_d          = '0;
          state_d        = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_FIN;
        end else begin
          idx_d        = idx_q + IDX_W'(1);
          req_d        = '0;
          req_d[idx_d] = 1'b1;
          cnt_d        = '0;
          state_d      = ST_REQ;
        end
      end
      ST_FIN: begin
        fdone_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_1MHZ_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      req_q    <= '0;
      ts_q     <= '0;
      flags_q  <= '0;
      ovr_q    <= '0;
      fstart_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      ts_q     <= ts_d;
      flags_q  <= flags_d;
      ovr_q    <= ovr_d;
      fstart_q <= fstart_d;
      fdone_q  <= fdone_d;
    end
  end

  assign SENSOR_REQ    = req_q;
  assign TIMESTAMP     = ts_q;
  assign FRAME_START   = fstart_q;
  assign FRAME_DONE    = fdone_q;
  assign TIMEOUT_FLAGS = flags_q;
  assign OVERRUN_CNT   = ovr_q;

endmodule

// File: tb/tb_sample_scheduler_10hz.sv
// Testbench for sample_scheduler_10hz with NUM_SENSORS=3, TIMEOUT_CYCLES=20
// and TS_WIDTH=4. Stimulus pushes one expected record per frame into a queue;
// a monitor measures REQ pulse widths and gaps and pops/compares a record at
// every FRAME_DONE pulse. A responder model raises DONE[i] so that it is
// sampled at the end of REQ cycle resp[i] (0 = sensor silent).
module tb_sample_scheduler_10hz;

  localparam int N  = 3;
  localparam int TO = 20;

  typedef struct {
    logic [3:0] ts;
    logic [2:0] flags;
    logic [7:0] ovr;
    int         len0;
    int         len1;
    int         len2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b1;
  logic [2:0] req;
  logic [2:0] done = '0;
  logic [3:0] ts;
  logic       fs;
  logic       fd;
  logic [2:0] flags;
  logic [7:0] ovr;

  int total = 0;
  int bad = 0;
  int frames_done = 0;
  int frames_started = 0;
  int frames_pushed = 0;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [3:0] model_ts = '0;
  logic [7:0] model_ovr = '0;

  int resp[3] = '{0, 0, 0};
  int rcnt[3] = '{0, 0, 0};

  int         len[3] = '{0, 0, 0};
  int         last_len[3] = '{0, 0, 0};
  int         since_drop = 0;
  bit         drop_seen = 1'b0;
  logic [2:0] prev_req = '0;

  sample_scheduler_10hz #(
    .NUM_SENSORS    (N),
    .TIMEOUT_CYCLES (TO),
    .TS_WIDTH       (4)
  ) dut (
    .CLK_1MHZ_IN   (clk),
    .RESET_N       (rst_n),
    .CLK_10HZ_IN   (tick_in),
    .SENSOR_REQ    (req),
    .SENSOR_DONE   (done),
    .TIMESTAMP     (ts),
    .FRAME_START   (fs),
    .FRAME_DONE    (fd),
    .TIMEOUT_FLAGS (flags),
    .OVERRUN_CNT   (ovr)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck design still ends the run with a report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sensor model: DONE[i] goes high in REQ cycle resp[i] and is held until
  // REQ[i] drops, so it is sampled at the end of that cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        rcnt[i]++;
        if (resp[i] != 0 && rcnt[i] == resp[i]) done[i] = 1'b1;
      end else begin
        rcnt[i] = 0;
        done[i] = 1'b0;
      end
    end
  end

  // Monitor: measures REQ widths, REQ-to-REQ gaps and drop-to-FRAME_DONE
  // latency, and checks each FRAME_DONE against the next expected record.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) len[i] = 0;
      prev_req   = '0;
      drop_seen  = 1'b0;
      since_drop = 0;
    end else begin
      if (drop_seen) since_drop++;
      checkOutput("req_onehot", ($countones(req) <= 1), 1);
      if (fs) frames_started++;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          len[i]++;
          if (!prev_req[i] && i != 0) checkOutput("req_gap", since_drop, 1);
        end else if (prev_req[i]) begin
          last_len[i] = len[i];
          len[i]      = 0;
          since_drop  = 0;
          drop_seen   = 1'b1;
        end
      end
      if (fd) begin
        frames_done++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_frame_done: got 1 expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("frame_ts", ts, mon_e.ts);
          checkOutput("frame_flags", flags, mon_e.flags);
          checkOutput("frame_overrun", ovr, mon_e.ovr);
          checkOutput("req0_len", last_len[0], mon_e.len0);
          checkOutput("req1_len", last_len[1], mon_e.len1);
          checkOutput("req2_len", last_len[2], mon_e.len2);
          checkOutput("done_latency", since_drop, 2);
        end
      end
      prev_req = req;
    end
  end

  // Runs one frame: sets sensor response times, pushes the expected frame
  // record, raises the frame clock and optionally injects overrun ticks.
  task automatic applyStimulus(input int r0, input int r1, input int r2, input int ovticks);
    exp_t e;
    int   rr[3];
    int   edges;
    int   fd_before;
    rr[0] = r0;
    rr[1] = r1;
    rr[2] = r2;
    for (int i = 0; i < N; i++) resp[i] = rr[i];
    model_ts = model_ts + 4'd1;
    e.ts  = model_ts + 4'(ovticks);
    e.ovr = model_ovr + 8'(ovticks);
    for (int i = 0; i < N; i++) e.flags[i] = (rr[i] == 0);
    e.len0 = (rr[0] == 0) ? TO : rr[0];
    e.len1 = (rr[1] == 0) ? TO : rr[1];
    e.len2 = (rr[2] == 0) ? TO : rr[2];
    exp_q.push_back(e);
    frames_pushed++;
    fd_before = frames_done;

    @(negedge clk);
    tick_in = 1'b1;
    edges = 0;
    while (edges < 8) begin
      @(posedge clk);
      edges++;
      #1;
      if (fs) break;
    end
    checkOutput("start_latency", edges, 3);
    checkOutput("start_ts", ts, model_ts);
    checkOutput("start_flags_clear", flags, 0);
    checkOutput("start_req0", req, 1);
    repeat (3) @(negedge clk);
    tick_in = 1'b0;

    if (ovticks > 0) begin
      repeat (6) @(negedge clk);
      for (int k = 0; k < ovticks; k++) begin
        tick_in = 1'b1;
        repeat (4) @(negedge clk);
        tick_in = 1'b0;
        repeat (6) @(negedge clk);
      end
      model_ts  = model_ts + 4'(ovticks);
      model_ovr = model_ovr + 8'(ovticks);
    end

    for (int c = 0; c < 400 && frames_done == fd_before; c++) @(negedge clk);
    if (frames_done == fd_before) checkOutput("frame_done_wait", frames_done, fd_before + 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    // Reset with the frame clock already high: releasing must not start a frame.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("hold_high_no_start", fs, 0);
      checkOutput("hold_high_req", req, 0);
    end
    checkOutput("reset_ts", ts, 0);
    checkOutput("reset_flags", flags, 0);
    checkOutput("reset_overrun", ovr, 0);
    checkOutput("reset_frame_done", fd, 0);
    checkOutput("reset_frames_started", frames_started, 0);
    tick_in = 1'b0;
    repeat (4) @(negedge clk);

    // Normal frame, then timeout on sensor 1, then flags cleared by next frame.
    applyStimulus(6, 6, 6, 0);
    applyStimulus(6, 0, 6, 0);
    applyStimulus(6, 6, 6, 0);
    // DONE[2] arrives on the same edge the timeout would fire: no flag.
    applyStimulus(3, 4, TO, 0);
    // All sensors silent with three ticks arriving mid-frame.
    applyStimulus(0, 0, 0, 3);

    // Asynchronous reset while REQ[1] is high.
    resp[0] = 6;
    resp[1] = 0;
    resp[2] = 6;
    @(negedge clk);
    tick_in = 1'b1;
    repeat (5) @(negedge clk);
    tick_in = 1'b0;
    for (int c = 0; c < 200 && !req[1]; c++) @(negedge clk);
    checkOutput("midframe_req1_high", req[1], 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_req", req, 0);
    checkOutput("async_reset_ts", ts, 0);
    checkOutput("async_reset_overrun", ovr, 0);
    checkOutput("async_reset_flags", flags, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_ts  = '0;
    model_ovr = '0;
    repeat (4) @(negedge clk);

    // Sixteen fast frames wrap the 4-bit timestamp back to zero.
    for (int f = 0; f < 16; f++) applyStimulus(1, 1, 1, 0);
    checkOutput("ts_wrap", ts, 0);

    repeat (10) @(negedge clk);
    checkOutput("expected_queue_empty", exp_q.size(), 0);
    checkOutput("frame_done_count", frames_done, frames_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_scheduler_10hz.md
# sample_scheduler_10hz

Consumes the 10 Hz frame clock produced by the 1 MHz→10 Hz divider and turns each rising edge into one sensor-poll frame in the 1 MHz domain. Per frame it advances a mission timestamp, then polls NUM_SENSORS sensor readers in fixed order 0..N-1 over a REQ/DONE handshake with a per-sensor timeout. It sits between the clock divider and the sensor reader blocks, and reports frame boundaries, timeouts and overruns to telemetry.

## Interface
- NUM_SENSORS, 3: number of polled sensor ports (1..8)
- TIMEOUT_CYCLES, 50000: max cycles REQ[i] stays high without DONE[i] (50 ms at 1 MHz); ≥2
- TS_WIDTH, 32: timestamp width

- CLK_1MHZ_IN  in  1  system clock, 1 MHz
- RESET_N  in  1  asynchronous, active-low reset
- CLK_10HZ_IN  in  1  10 Hz square wave from divider; treated as asynchronous
- SENSOR_REQ  out  NUM_SENSORS  poll request, at most one bit high
- SENSOR_DONE  in  NUM_SENSORS  sensor completion, level or pulse
- TIMESTAMP  out  TS_WIDTH  count of 10 Hz rising edges since reset
- FRAME_START  out  1  one-cycle pulse, frame begins
- FRAME_DONE  out  1  one-cycle pulse, all sensors handled
- TIMEOUT_FLAGS  out  NUM_SENSORS  bit i set if sensor i timed out in current/last frame
- OVERRUN_CNT  out  8  ticks arriving while a frame is in progress, saturating

## Operation
- Input sync: s1→s2→s3 registers on CLK_1MHZ_IN; tick = s2 & ~s3. All three reset to 1, so a high input at reset release produces no tick.
- FSM states: IDLE, REQ, GAP, FIN.
- IDLE: on tick → TIMESTAMP+1, FRAME_START=1, TIMEOUT_FLAGS cleared, idx=0, SENSOR_REQ[0]=1, timeout counter=0, go REQ.
- REQ: SENSOR_DONE[idx] sampled high → drop REQ, go GAP. Else if counter==TIMEOUT_CYCLES-1 → set TIMEOUT_FLAGS[idx], drop REQ, go GAP. Else counter+1.
- GAP (one cycle, REQ all low): if idx==NUM_SENSORS-1 go FIN, else idx+1, assert SENSOR_REQ[idx], counter=0, go REQ.
- FIN: FRAME_DONE=1 for one cycle, go IDLE.
- DONE bits of non-active sensors are ignored. DONE already high when REQ rises is accepted at the first edge (min 1 cycle REQ).
- DONE and timeout at the same edge: DONE wins, no flag.
- Tick in any state other than IDLE: TIMESTAMP+1 (time is never lost), OVERRUN_CNT+1 saturating at 255, frame not restarted, tick discarded.
- TIMESTAMP wraps 2^TS_WIDTH-1 → 0. Counter width = clog2(TIMEOUT_CYCLES).
- TIMEOUT_FLAGS hold from setting until the next FRAME_START.

## Timing
- Reset (RESET_N low, asynchronous): SENSOR_REQ=0, TIMESTAMP=0, FRAME_START=0, FRAME_DONE=0, TIMEOUT_FLAGS=0, OVERRUN_CNT=0, FSM=IDLE; effective immediately, including mid-frame (REQ drops without waiting for a clock).
- CLK_10HZ_IN first sampled high at edge k → FRAME_START, TIMESTAMP update and SENSOR_REQ[0] visible after edge k+2.
- REQ[i] first high cycle c0, DONE[i] sampled high at end of cycle cn → REQ[i] high n+1 cycles. The next REQ rises one cycle after the drop.
- Timeout: REQ[i] high exactly TIMEOUT_CYCLES cycles. The flag is visible in the same cycle REQ drops.
- FRAME_DONE is asserted one cycle after the last GAP, i.e. two cycles after the last REQ drops.
- All outputs are registered. There is no combinational path from SENSOR_DONE to SENSOR_REQ.

## Structure
- Shared package: FSM state encoding (IDLE/REQ/GAP/FIN), default NUM_SENSORS, TIMEOUT_CYCLES and TS_WIDTH constants, and the 8-bit OVERRUN saturation limit.
- Sub-module sync_rise_detect: 3-flop synchronizer plus rising-edge pulse, with reset value parameterised (1 here).

## Test plan
- Reset with CLK_10HZ_IN high, release, hold input high 10 cycles → no FRAME_START, all outputs 0.
- NUM_SENSORS=3, each DONE returned in the 6th REQ cycle → FRAME_START 3 edges after input rise; REQ[0], REQ[1], REQ[2] each 6 cycles high with 1-cycle gaps; FRAME_DONE 2 cycles after the last drop; TIMESTAMP=1; TIMEOUT_FLAGS=0.
- TIMEOUT_CYCLES=20, sensor 1 silent → REQ[1] high 20 cycles, TIMEOUT_FLAGS=3'b010, frame completes. On the next frame with sensor 1 responding, flags clear at FRAME_START.
- DONE[2] rises on the exact edge counter reaches TIMEOUT_CYCLES-1 → TIMEOUT_FLAGS[2]=0.
- TIMEOUT_CYCLES large, sensors silent, 3 ticks during one frame → OVERRUN_CNT=3, TIMESTAMP=4, a single FRAME_DONE.
- RESET_N pulsed low while REQ[1] high → REQ drops asynchronously, TIMESTAMP=0. TS_WIDTH=4 with 16 ticks → TIMESTAMP wraps to 0.
